// File: rtl/jtkunio_romarb.sv
// ============================================================================
//  Module   : jtkunio_romarb
//  Purpose  : Shares one SDRAM bank between the main CPU, sound CPU and PCM
//             byte-wide ROM ports. Each port has a one-word cache that serves
//             hits combinationally. Misses are fetched one at a time over a
//             single rd/ack/rdy channel.
//  Config   : JTKUNIO_ROMARB_RR_EN - when defined, round-robin arbitration
//             (main -> snd -> pcm); otherwise fixed priority main > pcm > snd.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtkunio_romarb #(
  parameter logic [21:0] SND_OFFSET = 22'h08000,
  parameter logic [21:0] PCM_OFFSET = 22'h0C000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,

  input  logic        main_cs,
  input  logic [15:0] main_addr,
  output logic [7:0]  main_data,
  output logic        main_ok,

  input  logic        snd_cs,
  input  logic [14:0] snd_addr,
  output logic [7:0]  snd_data,
  output logic        snd_ok,

  input  logic        pcm_cs,
  input  logic [16:0] pcm_addr,
  output logic [7:0]  pcm_data,
  output logic        pcm_ok,

  output logic [21:0] sdram_addr,
  output logic        sdram_rd,
  input  logic        sdram_ack,
  input  logic        sdram_rdy,
  input  logic [15:0] sdram_din
);

  // Fetch state machine encoding
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_ACK = 2'd1;
  localparam logic [1:0] ST_WAIT_RDY = 2'd2;

  // Requester identifiers (also the round-robin rotation order)
  localparam logic [1:0] REQ_MAIN = 2'd0;
  localparam logic [1:0] REQ_SND  = 2'd1;
  localparam logic [1:0] REQ_PCM  = 2'd2;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]  state_q,       state_d;
  logic [1:0]  winner_q,      winner_d;
  logic        sdram_rd_q,    sdram_rd_d;
  logic [21:0] sdram_addr_q,  sdram_addr_d;
  logic [15:0] fetch_word_q,  fetch_word_d;   // word address being fetched
  logic        discard_q,     discard_d;      // flush seen during this fetch

  logic        main_valid_q,  main_valid_d;
  logic [14:0] main_tag_q,    main_tag_d;
  logic [15:0] main_cache_q,  main_cache_d;

  logic        snd_valid_q,   snd_valid_d;
  logic [13:0] snd_tag_q,     snd_tag_d;
  logic [15:0] snd_cache_q,   snd_cache_d;

  logic        pcm_valid_q,   pcm_valid_d;
  logic [15:0] pcm_tag_q,     pcm_tag_d;
  logic [15:0] pcm_cache_q,   pcm_cache_d;

`ifdef JTKUNIO_ROMARB_RR_EN
  logic [1:0]  rr_ptr_q,      rr_ptr_d;       // requester with top priority
`endif

  // --------------------------------------------------------------------------
  // Address decode and hit detection
  // --------------------------------------------------------------------------
  logic [14:0] main_word;
  logic [13:0] snd_word;
  logic [15:0] pcm_word;
  logic        main_hit, snd_hit, pcm_hit;
  logic        main_pend, snd_pend, pcm_pend;

  assign main_word = main_addr[15:1];
  assign snd_word  = snd_addr[14:1];
  assign pcm_word  = pcm_addr[16:1];

  assign main_hit  = main_cs & main_valid_q & (main_tag_q == main_word);
  assign snd_hit   = snd_cs  & snd_valid_q  & (snd_tag_q  == snd_word);
  assign pcm_hit   = pcm_cs  & pcm_valid_q  & (pcm_tag_q  == pcm_word);

  assign main_pend = main_cs & ~main_hit;
  assign snd_pend  = snd_cs  & ~snd_hit;
  assign pcm_pend  = pcm_cs  & ~pcm_hit;

  assign main_ok   = main_hit;
  assign snd_ok    = snd_hit;
  assign pcm_ok    = pcm_hit;

  // Byte lane select: address bit 0 set picks the upper byte
  assign main_data = main_addr[0] ? main_cache_q[15:8] : main_cache_q[7:0];
  assign snd_data  = snd_addr[0]  ? snd_cache_q[15:8]  : snd_cache_q[7:0];
  assign pcm_data  = pcm_addr[0]  ? pcm_cache_q[15:8]  : pcm_cache_q[7:0];

  assign sdram_rd   = sdram_rd_q;
  assign sdram_addr = sdram_addr_q;

  // --------------------------------------------------------------------------
  // Arbitration among pending misses
  // --------------------------------------------------------------------------
  logic        grant_any;
  logic [1:0]  grant_sel;
  logic [15:0] grant_word;
  logic [21:0] grant_addr;

  // Pick the winning requester from the pending set
  always_comb begin
    grant_any = main_pend | snd_pend | pcm_pend;
    grant_sel = REQ_MAIN;
`ifdef JTKUNIO_ROMARB_RR_EN
    case (rr_ptr_q)
      REQ_SND: begin
        if      (snd_pend)  grant_sel = REQ_SND;
        else if (pcm_pend)  grant_sel = REQ_PCM;
        else if (main_pend) grant_sel = REQ_MAIN;
      end
      REQ_PCM: begin
        if      (pcm_pend)  grant_sel = REQ_PCM;
        else if (main_pend) grant_sel = REQ_MAIN;
        else if (snd_pend)  grant_sel = REQ_SND;
      end
      default: begin
        if      (main_pend) grant_sel = REQ_MAIN;
        else if (snd_pend)  grant_sel = REQ_SND;
        else if (pcm_pend)  grant_sel = REQ_PCM;
      end
    endcase
`else
    if      (main_pend) grant_sel = REQ_MAIN;
    else if (pcm_pend)  grant_sel = REQ_PCM;
    else if (snd_pend)  grant_sel = REQ_SND;
`endif
  end

  // Word address and SDRAM address of the winner (sums wrap at 22 bits)
  always_comb begin
    grant_word = {1'b0, main_word};
    grant_addr = {7'd0, main_word};
    case (grant_sel)
      REQ_SND: begin
        grant_word = {2'b00, snd_word};
        grant_addr = SND_OFFSET + {8'd0, snd_word};
      end
      REQ_PCM: begin
        grant_word = pcm_word;
        grant_addr = PCM_OFFSET + {6'd0, pcm_word};
      end
      default: begin
        grant_word = {1'b0, main_word};
        grant_addr = {7'd0, main_word};
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Fetch FSM
  // --------------------------------------------------------------------------
  logic fill_en;

  // Sequence one fetch at a time: request, wait for accept, wait for data
  always_comb begin
    state_d      = state_q;
    winner_d     = winner_q;
    sdram_rd_d   = sdram_rd_q;
    sdram_addr_d = sdram_addr_q;
    fetch_word_d = fetch_word_q;
    discard_d    = discard_q | flush;
    fill_en      = 1'b0;
`ifdef JTKUNIO_ROMARB_RR_EN
    rr_ptr_d     = rr_ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!flush && grant_any) begin
          state_d      = ST_WAIT_ACK;
          winner_d     = grant_sel;
          sdram_rd_d   = 1'b1;
          sdram_addr_d = grant_addr;
          fetch_word_d = grant_word;
          discard_d    = 1'b0;
`ifdef JTKUNIO_ROMARB_RR_EN
          // The granted requester drops to lowest priority
          case (grant_sel)
            REQ_MAIN: rr_ptr_d = REQ_SND;
            REQ_SND:  rr_ptr_d = REQ_PCM;
            default:  rr_ptr_d = REQ_MAIN;
          endcase
`endif
        end
      end
      ST_WAIT_ACK: begin
        if (sdram_ack) begin
          sdram_rd_d = 1'b0;
          // Data arriving together with the accept completes the fetch now
          if (sdram_rdy) begin
            fill_en = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT_RDY;
          end
        end
      end
      ST_WAIT_RDY: begin
        if (sdram_rdy) begin
          fill_en = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        sdram_rd_d = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Cache update
  // --------------------------------------------------------------------------
  logic fill_valid;

  assign fill_valid = ~(discard_q | flush);

  // Load the fetched word into the winner's cache; flush wipes all valid bits
  always_comb begin
    main_valid_d = main_valid_q;
    main_tag_d   = main_tag_q;
    main_cache_d = main_cache_q;
    snd_valid_d  = snd_valid_q;
    snd_tag_d    = snd_tag_q;
    snd_cache_d  = snd_cache_q;
    pcm_valid_d  = pcm_valid_q;
    pcm_tag_d    = pcm_tag_q;
    pcm_cache_d  = pcm_cache_q;
    if (fill_en) begin
      case (winner_q)
        REQ_SND: begin
          snd_valid_d = fill_valid;
          snd_tag_d   = fetch_word_q[13:0];
          snd_cache_d = sdram_din;
        end
        REQ_PCM: begin
          pcm_valid_d = fill_valid;
          pcm_tag_d   = fetch_word_q;
          pcm_cache_d = sdram_din;
        end
        default: begin
          main_valid_d = fill_valid;
          main_tag_d   = fetch_word_q[14:0];
          main_cache_d = sdram_din;
        end
      endcase
    end
    if (flush) begin
      main_valid_d = 1'b0;
      snd_valid_d  = 1'b0;
      pcm_valid_d  = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------

  // Register FSM, request channel and cache contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      winner_q     <= REQ_MAIN;
      sdram_rd_q   <= 1'b0;
      sdram_addr_q <= 22'd0;
      fetch_word_q <= 16'd0;
      discard_q    <= 1'b0;
      main_valid_q <= 1'b0;
      main_tag_q   <= 15'd0;
      main_cache_q <= 16'd0;
      snd_valid_q  <= 1'b0;
      snd_tag_q    <= 14'd0;
      snd_cache_q  <= 16'd0;
      pcm_valid_q  <= 1'b0;
      pcm_tag_q    <= 16'd0;
      pcm_cache_q  <= 16'd0;
`ifdef JTKUNIO_ROMARB_RR_EN
      rr_ptr_q     <= REQ_MAIN;
`endif
    end else begin
      state_q      <= state_d;
      winner_q     <= winner_d;
      sdram_rd_q   <= sdram_rd_d;
      sdram_addr_q <= sdram_addr_d;
      fetch_word_q <= fetch_word_d;
      discard_q    <= discard_d;
      main_valid_q <= main_valid_d;
      main_tag_q   <= main_tag_d;
      main_cache_q <= main_cache_d;
      snd_valid_q  <= snd_valid_d;
      snd_tag_q    <= snd_tag_d;
      snd_cache_q  <= snd_cache_d;
      pcm_valid_q  <= pcm_valid_d;
      pcm_tag_q    <= pcm_tag_d;
      pcm_cache_q  <= pcm_cache_d;
`ifdef JTKUNIO_ROMARB_RR_EN
      rr_ptr_q     <= rr_ptr_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_jtkunio_romarb.sv
// ============================================================================
//  Module   : tb_jtkunio_romarb
//  Purpose  : Self-checking bench for jtkunio_romarb: directed scenarios
//             followed by randomized traffic against a reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jtkunio_romarb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        main_cs, snd_cs, pcm_cs;
  logic [15:0] main_addr;
  logic [14:0] snd_addr;
  logic [16:0] pcm_addr;
  logic [7:0]  main_data, snd_data, pcm_data;
  logic        main_ok, snd_ok, pcm_ok;
  logic [21:0] sdram_addr;
  logic        sdram_rd;
  logic        sdram_ack, sdram_rdy;
  logic [15:0] sdram_din;

  int total = 0;
  int bad   = 0;

  // Reference model: one-word caches plus the fetch in progress
  int          ph;          // 0 idle, 1 requesting, 2 awaiting data
  logic [21:0] req_addr;
  logic        m_valid [3];
  int          m_word  [3];
  logic [15:0] m_data  [3];
  logic        m_abort;
  int          rr_ptr;
  int          flush_cnt;

  always #5 clk = ~clk;

  jtkunio_romarb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .main_cs    (main_cs),
    .main_addr  (main_addr),
    .main_data  (main_data),
    .main_ok    (main_ok),
    .snd_cs     (snd_cs),
    .snd_addr   (snd_addr),
    .snd_data   (snd_data),
    .snd_ok     (snd_ok),
    .pcm_cs     (pcm_cs),
    .pcm_addr   (pcm_addr),
    .pcm_data   (pcm_data),
    .pcm_ok     (pcm_ok),
    .sdram_addr (sdram_addr),
    .sdram_rd   (sdram_rd),
    .sdram_ack  (sdram_ack),
    .sdram_rdy  (sdram_rdy),
    .sdram_din  (sdram_din)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [21:0] a);
    return a[15:0] ^ {a[7:0], a[15:8]} ^ 16'h5AC3 ^ {10'd0, a[21:16]};
  endfunction

  // Index 0 main, 1 snd, 2 pcm
  function automatic logic [21:0] off_of(input int i);
    if (i == 1) return 22'h08000;
    if (i == 2) return 22'h0C000;
    return 22'h00000;
  endfunction

  function automatic int word_of(input int i);
    if (i == 1) return int'({18'd0, snd_addr[14:1]});
    if (i == 2) return int'({16'd0, pcm_addr[16:1]});
    return int'({17'd0, main_addr[15:1]});
  endfunction

  function automatic logic cs_of(input int i);
    if (i == 1) return snd_cs;
    if (i == 2) return pcm_cs;
    return main_cs;
  endfunction

  function automatic logic upper_of(input int i);
    if (i == 1) return snd_addr[0];
    if (i == 2) return pcm_addr[0];
    return main_addr[0];
  endfunction

  function automatic logic hit_of(input int i);
    return cs_of(i) && m_valid[i] && (m_word[i] == word_of(i));
  endfunction

  // Sound and PCM windows in SDRAM are disjoint from main's 32K words
  function automatic int decode(input logic [21:0] a);
    if (a < 22'h08000) return 0;
    if (a < 22'h0C000) return 1;
    return 2;
  endfunction

  function automatic int pick();
    int order [3];
`ifdef JTKUNIO_ROMARB_RR_EN
    for (int k = 0; k < 3; k++) order[k] = (rr_ptr + k) % 3;
`else
    order[0] = 0; order[1] = 2; order[2] = 1;
`endif
    for (int k = 0; k < 3; k++)
      if (cs_of(order[k]) && !hit_of(order[k])) return order[k];
    return -1;
  endfunction

  task automatic model_reset();
    ph = 0; req_addr = 22'd0; m_abort = 1'b0; rr_ptr = 0;
    for (int i = 0; i < 3; i++) begin
      m_valid[i] = 1'b0; m_word[i] = 0; m_data[i] = 16'd0;
    end
  endtask

  task automatic model_fill();
    int i;
    i = decode(req_addr);
    m_word[i]  = int'(req_addr - off_of(i));
    m_data[i]  = sdram_din;
    m_valid[i] = !m_abort && !flush;
  endtask

  // Check outputs mid-cycle, advance the model, return just after the edge
  task automatic tick();
    int w;
    logic [7:0] eb;
    @(negedge clk);
    chk("main_ok", {31'd0, main_ok}, {31'd0, hit_of(0)});
    chk("snd_ok",  {31'd0, snd_ok},  {31'd0, hit_of(1)});
    chk("pcm_ok",  {31'd0, pcm_ok},  {31'd0, hit_of(2)});
    if (hit_of(0)) begin
      eb = upper_of(0) ? m_data[0][15:8] : m_data[0][7:0];
      chk("main_data", {24'd0, main_data}, {24'd0, eb});
    end
    if (hit_of(1)) begin
      eb = upper_of(1) ? m_data[1][15:8] : m_data[1][7:0];
      chk("snd_data", {24'd0, snd_data}, {24'd0, eb});
    end
    if (hit_of(2)) begin
      eb = upper_of(2) ? m_data[2][15:8] : m_data[2][7:0];
      chk("pcm_data", {24'd0, pcm_data}, {24'd0, eb});
    end
    chk("sdram_rd", {31'd0, sdram_rd}, {31'd0, (ph == 1)});
    if (ph == 1) chk("sdram_addr", {10'd0, sdram_addr}, {10'd0, req_addr});
    case (ph)
      0: if (!flush) begin
        w = pick();
        if (w >= 0) begin
          req_addr = off_of(w) + 22'(word_of(w));
          ph = 1; m_abort = 1'b0; rr_ptr = (w + 1) % 3;
        end
      end
      1: if (sdram_ack) begin
        if (sdram_rdy) begin model_fill(); ph = 0; end
        else ph = 2;
      end
      default: if (sdram_rdy) begin model_fill(); ph = 0; end
    endcase
    if (flush) begin
      for (int i = 0; i < 3; i++) m_valid[i] = 1'b0;
      m_abort = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_ack();
    sdram_ack = 1'b1; tick(); sdram_ack = 1'b0;
  endtask

  task automatic do_rdy(input logic [15:0] d);
    sdram_din = d; sdram_rdy = 1'b1; tick(); sdram_rdy = 1'b0;
  endtask

  task automatic drive_bank();
    sdram_ack = 1'b0; sdram_rdy = 1'b0;
    if (ph == 1) begin
      sdram_ack = ($urandom_range(0, 1) == 1);
      sdram_rdy = sdram_ack && ($urandom_range(0, 3) == 0);
    end else if (ph == 2) begin
      sdram_rdy = ($urandom_range(0, 2) == 0);
    end
    sdram_din = mem_word(req_addr);
  endtask

  // Requesters hold cs/addr while missing, otherwise wander over a few words
  task automatic drive_req();
    if (!(main_cs && !hit_of(0)) && $urandom_range(0, 3) == 0) begin
      main_cs = ($urandom_range(0, 3) != 0);
      main_addr = {12'h030, 4'($urandom_range(0, 15))};
    end
    if (!(snd_cs && !hit_of(1)) && $urandom_range(0, 3) == 0) begin
      snd_cs = ($urandom_range(0, 3) != 0);
      snd_addr = {11'h010, 4'($urandom_range(0, 15))};
    end
    if (!(pcm_cs && !hit_of(2)) && $urandom_range(0, 3) == 0) begin
      pcm_cs = ($urandom_range(0, 3) != 0);
      pcm_addr = {13'h0050, 4'($urandom_range(0, 15))};
    end
    if (flush_cnt > 0) flush_cnt--;
    else if ($urandom_range(0, 49) == 0) flush_cnt = $urandom_range(1, 3);
    flush = (flush_cnt > 0);
  endtask

  initial begin
    logic [21:0] first_a, second_a;
    rst_n = 1'b0; flush = 1'b0;
    main_cs = 1'b0; snd_cs = 1'b0; pcm_cs = 1'b0;
    main_addr = 16'd0; snd_addr = 15'd0; pcm_addr = 17'd0;
    sdram_ack = 1'b0; sdram_rdy = 1'b0; sdram_din = 16'd0;
    flush_cnt = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd",   {31'd0, sdram_rd}, 32'd0);
    chk("rst_addr", {10'd0, sdram_addr}, 32'd0);
    chk("rst_ok",   {29'd0, main_ok, snd_ok, pcm_ok}, 32'd0);
    rst_n = 1'b1;

    // Main miss, fetch, byte select and sibling-byte hit
    main_cs = 1'b1; main_addr = 16'h1235;
    tick();
    chk("main_req_rd",   {31'd0, sdram_rd}, 32'd1);
    chk("main_req_addr", {10'd0, sdram_addr}, 32'h0091A);
    do_ack();
    do_rdy(16'hABCD);
    chk("main_hit_ok",   {31'd0, main_ok}, 32'd1);
    chk("main_hit_hi",   {24'd0, main_data}, 32'hAB);
    main_addr = 16'h1234;
    #1;
    chk("main_lo_ok",    {31'd0, main_ok}, 32'd1);
    chk("main_lo_data",  {24'd0, main_data}, 32'hCD);
    tick();
    chk("main_no_refetch", {31'd0, sdram_rd}, 32'd0);

    // Simultaneous sound and PCM misses
    main_cs = 1'b0;
    snd_cs = 1'b1; snd_addr = 15'h0002;
    pcm_cs = 1'b1; pcm_addr = 17'h00004;
`ifdef JTKUNIO_ROMARB_RR_EN
    first_a = 22'h08001; second_a = 22'h0C002;
`else
    first_a = 22'h0C002; second_a = 22'h08001;
`endif
    tick();
    chk("arb_first", {10'd0, sdram_addr}, {10'd0, first_a});
    do_ack();
    do_rdy(mem_word(req_addr));
    tick();
    chk("arb_second", {10'd0, sdram_addr}, {10'd0, second_a});
    do_ack();
    do_rdy(mem_word(req_addr));
    chk("arb_snd_ok", {31'd0, snd_ok}, 32'd1);
    chk("arb_pcm_ok", {31'd0, pcm_ok}, 32'd1);

    // Flush while waiting for data
    snd_cs = 1'b0; pcm_cs = 1'b0;
    main_cs = 1'b1; main_addr = 16'h0200;
    tick();
    chk("fl_req_addr", {10'd0, sdram_addr}, 32'h00100);
    do_ack();
    flush = 1'b1;
    tick();
    do_rdy(16'h1357);
    chk("fl_ok_low", {31'd0, main_ok}, 32'd0);
    chk("fl_idle",   {31'd0, sdram_rd}, 32'd0);
    tick();
    chk("fl_no_start", {31'd0, sdram_rd}, 32'd0);
    flush = 1'b0;
    tick();
    chk("fl_refetch_rd",   {31'd0, sdram_rd}, 32'd1);
    chk("fl_refetch_addr", {10'd0, sdram_addr}, 32'h00100);
    do_ack();
    do_rdy(16'h2468);
    chk("fl_refetch_ok", {31'd0, main_ok}, 32'd1);

    // Address change between accept and data
    main_addr = 16'h0000;
    tick();
    chk("chg_addr0", {10'd0, sdram_addr}, 32'h00000);
    do_ack();
    main_addr = 16'h0100;
    do_rdy(16'h1111);
    chk("chg_ok_low", {31'd0, main_ok}, 32'd0);
    tick();
    chk("chg_refetch", {10'd0, sdram_addr}, 32'h00080);
    do_ack();
    do_rdy(16'h2222);
    chk("chg_ok", {31'd0, main_ok}, 32'd1);

    // Asynchronous reset while waiting for accept
    main_addr = 16'h4000;
    tick();
    chk("ar_rd_pre", {31'd0, sdram_rd}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_rd_now", {31'd0, sdram_rd}, 32'd0);
    chk("ar_ok_now", {29'd0, main_ok, snd_ok, pcm_ok}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("ar_restart", {10'd0, sdram_addr}, 32'h02000);
    do_ack();
    do_rdy(16'h3333);
    chk("ar_ok", {31'd0, main_ok}, 32'd1);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      drive_req();
      drive_bank();
      tick();
    end
    flush = 1'b0; flush_cnt = 0;
    main_cs = 1'b0; snd_cs = 1'b0; pcm_cs = 1'b0;
    for (int n = 0; n < 20; n++) begin
      drive_bank();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/jtkunio_romarb.md
Name: jtkunio_romarb

Overview:
Shares one SDRAM bank between the three byte-wide sound/CPU ROM requesters: main CPU, sound CPU and PCM.
- Each requester has a one-word (16-bit) cache in front of it; hits are served combinationally.
- Misses are fetched over a single ba_rd/ack/rdy channel, one at a time, under fixed priority (or round-robin, see Optional Feature).
- Sits between the CPU/sound ROM ports and the SDRAM bank controller inside the game SDRAM wrapper.

Parameters:
SND_OFFSET, 22'h08000, SDRAM word offset added to sound ROM word address
PCM_OFFSET, 22'h0C000, SDRAM word offset added to PCM ROM word address

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
flush  in  1  invalidate all caches (held high while downloading)
main_cs  in  1  main ROM request
main_addr  in  16  main byte address
main_data  out  8  main byte
main_ok  out  1  main_data valid for current main_addr
snd_cs  in  1  sound ROM request
snd_addr  in  15  sound byte address
snd_data  out  8  sound byte
snd_ok  out  1  snd_data valid
pcm_cs  in  1  PCM ROM request
pcm_addr  in  17  PCM byte address
pcm_data  out  8  PCM byte
pcm_ok  out  1  pcm_data valid
sdram_addr  out  22  word address to bank controller
sdram_rd  out  1  read request
sdram_ack  in  1  request accepted
sdram_rdy  in  1  sdram_din valid (single cycle)
sdram_din  in  16  read word

Behaviour:
- Address mapping:
  - Word address = byte addr >> 1; byte select = addr[0] (1 = upper byte [15:8]).
  - SDRAM address = offset + zero-extended word address; main offset 0. Sums wrap modulo 2^22.
- Per-requester cache: valid bit, word tag, 16-bit data.
  - hit = cs & valid & (tag == word address).
  - x_ok = hit, combinational. x_data = selected byte of cached data, combinational.
  - x_ok is 0 whenever cs = 0.
- Requester contract: hold addr and cs stable until ok. The block tolerates violations; ok simply tracks tag match.
- FSM states:
  - IDLE: pending set = {cs & !hit}, evaluated per requester. If non-empty, register the winner and its sdram_addr, set sdram_rd = 1, go to WAIT_ACK. Fixed priority: main > pcm > snd.
  - WAIT_ACK: hold sdram_rd and sdram_addr. On sdram_ack, drop sdram_rd next cycle, go to WAIT_RDY.
  - WAIT_RDY: on sdram_rdy, write sdram_din into the winner's cache, set its tag to the fetched word address and valid = 1, then return to IDLE.
- Latency: miss at cycle 0 -> sdram_rd high at cycle 1. Given ack at n and rdy at m > n, ok is high at m+1.
- Only one fetch is outstanding. Other requesters' hits keep being served during a fetch.
- Address change mid-fetch:
  - The fetch completes and caches the old word; ok stays low.
  - A new miss is raised from IDLE.
- flush:
  - Clears all valid bits in the same cycle; ok drops the next cycle.
  - A fetch in flight completes its handshake, but the result is not marked valid.
  - While flush is high, no new fetch is started.
- Reset values: all valid = 0, state IDLE, sdram_rd = 0, sdram_addr = 0, cache data = 0, winner = main. Async reset mid-fetch aborts to IDLE immediately; the bank controller must be reset too.
- Simultaneous sdram_ack and sdram_rdy in WAIT_ACK: treat as ack followed by rdy; data is written that cycle and the FSM returns to IDLE.

Optional Feature:
JTKUNIO_ROMARB_RR_EN
- Defined: round-robin arbitration. Order rotates main -> snd -> pcm. After a grant, the granted requester gets lowest priority for the next decision; reset pointer favours main.
- Undefined: fixed priority main > pcm > snd.

Test Plan:
- Reset, then main_cs = 1 with main_addr = 16'h1235; bank returns 16'hABCD. Expect:
  - sdram_rd at cycle 1, sdram_addr = 22'h0091A;
  - after rdy: main_ok = 1, main_data = 8'hAB;
  - switch to 16'h1234 -> immediate main_ok, data 8'hCD, no new sdram_rd.
- snd_addr = 15'h0002 and pcm_addr = 17'h00004 both missing at the same time (fixed priority). Expect:
  - first fetch at 22'h0C002 (pcm);
  - then 22'h08001 (snd);
  - both ok after their respective rdy.
- With JTKUNIO_ROMARB_RR_EN, all three missing continuously with fresh addresses. Expect grant order main, snd, pcm, main…, and no requester granted twice in a row while others wait.
- flush asserted in WAIT_RDY. Expect:
  - rdy accepted and FSM back in IDLE;
  - target ok stays 0;
  - after flush drops, the same address is refetched.
- main_addr changed from 16'h0000 to 16'h0100 between ack and rdy. Expect main_ok = 0 after rdy, then a second fetch at 22'h00080 and ok after its rdy.
- rst_n pulsed low in WAIT_ACK. Expect sdram_rd = 0 immediately and all ok = 0; a fresh request restarts cleanly.
